// File: rtl/ddr_ctl1_sequencer_pkg.sv
// DdrCtl1 opcode constants and sequencer state encoding shared across the slice.
package ddr_ctl1_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LA0 = 4'h1;
  localparam logic [3:0] OP_LA1 = 4'h2;
  localparam logic [3:0] OP_LA2 = 4'h3;
  localparam logic [3:0] OP_LA3 = 4'h4;
  localparam logic [3:0] OP_LD0 = 4'h5;
  localparam logic [3:0] OP_LD1 = 4'h6;
  localparam logic [3:0] OP_LD2 = 4'h7;
  localparam logic [3:0] OP_LD3 = 4'h8;
  localparam logic [3:0] OP_WRP = 4'h9;
  localparam logic [3:0] OP_RDP = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_D,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] n);
    return word[{n, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddr_ctl1_sequencer_if.sv
// Page request/response handshake between a requester and the DdrCtl1 sequencer.
interface ddr_ctl1_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ddr_ctl1_addr_cache.sv
// Shadow of the address bytes last loaded into DdrCtl1; flags bytes that must be reloaded
// and finds the first such byte at or above a start index (combinational lookup).
module ddr_ctl1_addr_cache #(
  parameter bit SKIP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cmp_addr,
  input  logic [1:0]  from_idx,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  output logic [3:0]  differs,
  output logic [1:0]  first_idx,
  output logic        any_diff
);
  import ddr_ctl1_sequencer_pkg::*;

  logic [31:0] bytes_q;
  logic        valid_q;
  logic [3:0]  masked;

  always_ff @(posedge clock) begin
    if (reset) begin
      bytes_q <= '0;
      valid_q <= 1'b0;
    end else if (wr_en) begin
      bytes_q[{wr_idx, 3'b000} +: 8] <= byte_of(cmp_addr, wr_idx);
      // an invalid cache forces all four loads, so LA3 completes the first full load
      if (wr_idx == 2'd3) valid_q <= 1'b1;
    end
  end

  always_comb begin
    differs   = '0;
    first_idx = '0;
    for (int i = 0; i < 4; i++) begin
      differs[i] = !valid_q || !SKIP ||
                   (byte_of(bytes_q, 2'(i)) != byte_of(cmp_addr, 2'(i)));
    end
    masked   = differs & (4'b1111 << from_idx);
    any_diff = |masked;
    for (int i = 3; i >= 0; i--) begin
      if (masked[i]) first_idx = 2'(i);
    end
  end

endmodule

// File: rtl/ddr_ctl1_sequencer.sv
// Expands whole-page requests into the DdrCtl1 LA/LD/WRP/RDP stream, paced by ctl_ready.
// First instruction the cycle after accept; req_ready only in IDLE, one request in flight.
module ddr_ctl1_sequencer #(
  parameter bit SKIP_REDUNDANT_LA = 1'b1,
  parameter int BUSY_WAIT         = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ddr_ctl1_sequencer_if.slave  host,
  output logic [11:0]          ctl_inst,
  output logic                 ctl_inst_en,
  input  logic [31:0]          ctl_page,
  input  logic                 ctl_ready
);
  import ddr_ctl1_sequencer_pkg::*;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [31:0] rsp_hold_q;

  logic        in_idle;
  logic [3:0]  differs;
  logic [1:0]  first_idx;
  logic        any_diff;
  logic        more_la;
  logic        la_fire;

  assign in_idle = (state_q == S_IDLE);
  assign la_fire = (state_q == S_LOAD_A) && ctl_ready && !reset;
  // bytes above the one being emitted now; writing the cache never touches them
  assign more_la = |(differs & (4'b1110 << first_idx));

  ddr_ctl1_addr_cache #(.SKIP(SKIP_REDUNDANT_LA)) u_cache (
    .clock     (clock),
    .reset     (reset),
    .cmp_addr  (in_idle ? host.req_addr : addr_q),
    .from_idx  (in_idle ? 2'd0 : idx_q),
    .wr_en     (la_fire),
    .wr_idx    (first_idx),
    .differs   (differs),
    .first_idx (first_idx),
    .any_diff  (any_diff)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rsp_hold_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (host.req_valid) begin
          wr_q   <= host.req_write;
          addr_q <= host.req_addr;
          data_q <= host.req_data;
          idx_q  <= '0;
        end
        S_LOAD_A:    if (ctl_ready) idx_q <= more_la ? first_idx + 2'd1 : 2'd0;
        S_LOAD_D:    if (ctl_ready) idx_q <= idx_q + 2'd1;
        S_ISSUE:     cnt_q <= '0;
        S_WAIT_BUSY: cnt_q <= cnt_q + 8'd1;
        S_RESP:      if (!wr_q) rsp_hold_q <= ctl_page;
        default:     ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    ctl_inst       = {OP_NOP, 8'h00};
    ctl_inst_en    = 1'b0;
    host.req_ready = 1'b0;
    host.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        host.req_ready = 1'b1;
        if (host.req_valid)
          state_d = any_diff ? S_LOAD_A : (host.req_write ? S_LOAD_D : S_ISSUE);
      end
      S_LOAD_A: if (ctl_ready) begin
        ctl_inst    = {OP_LA0 + {2'b00, first_idx}, byte_of(addr_q, first_idx)};
        ctl_inst_en = 1'b1;
        if (!more_la) state_d = wr_q ? S_LOAD_D : S_ISSUE;
      end
      S_LOAD_D: if (ctl_ready) begin
        ctl_inst    = {OP_LD0 + {2'b00, idx_q}, byte_of(data_q, idx_q)};
        ctl_inst_en = 1'b1;
        if (idx_q == 2'd3) state_d = S_ISSUE;
      end
      S_ISSUE: if (ctl_ready) begin
        ctl_inst    = {wr_q ? OP_WRP : OP_RDP, 8'h00};
        ctl_inst_en = 1'b1;
        state_d     = S_WAIT_BUSY;
      end
      // a controller that never shows busy is assumed to have started after BUSY_WAIT cycles
      S_WAIT_BUSY: if (!ctl_ready || cnt_q == 8'(BUSY_WAIT - 1)) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (ctl_ready) state_d = S_RESP;
      S_RESP: begin
        host.rsp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      ctl_inst       = {OP_NOP, 8'h00};
      ctl_inst_en    = 1'b0;
      host.req_ready = 1'b0;
      host.rsp_valid = 1'b0;
    end
  end

  always_comb begin
    if (reset)                                  host.rsp_data = '0;
    else if (state_q == S_RESP && !wr_q)        host.rsp_data = ctl_page;
    else                                        host.rsp_data = rsp_hold_q;
  end

endmodule

// File: tb/tb_ddr_ctl1_sequencer.sv
// Directed bench: write/read/partial-LA/stall/busy-timeout/reset scenarios with hand-derived cycle expectations.
module tb_ddr_ctl1_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] ctl_inst;
  logic        ctl_inst_en;
  logic [31:0] ctl_page = 32'hDDCCBBAA;
  logic        ctl_ready = 1'b1;
  int          total = 0;
  int          bad = 0;

  ddr_ctl1_sequencer_if bus ();

  ddr_ctl1_sequencer #(.SKIP_REDUNDANT_LA(1'b1), .BUSY_WAIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .host        (bus.slave),
    .ctl_inst    (ctl_inst),
    .ctl_inst_en (ctl_inst_en),
    .ctl_page    (ctl_page),
    .ctl_ready   (ctl_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {en, opcode, imm} as one word
  task automatic chk_inst(input string tag, input logic [12:0] exp);
    chk(tag, {19'b0, ctl_inst_en, ctl_inst}, {19'b0, exp});
  endtask

  // next cycle: drive ctl_ready, drop req_valid, leave time for outputs to settle
  task automatic step(input logic rdy);
    @(posedge clock);
    #1;
    ctl_ready     = rdy;
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_data  = data;
    #1;
  endtask

  logic [12:0] w1 [9];
  logic [12:0] w3 [4];
  logic [12:0] r4 [5];

  initial begin
    w1 = '{13'h1112, 13'h123F, 13'h132B, 13'h1400, 13'h15AA,
           13'h16BB, 13'h17CC, 13'h18DD, 13'h1900};
    w3 = '{13'h1401, 13'h1511, 13'h1622, 13'h1733};
    r4 = '{13'h1112, 13'h123F, 13'h132B, 13'h1401, 13'h1A00};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // reset state
    step(1);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk_inst("rst_inst", 13'h0000);
    step(1);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    // full write: LA0..LA3, LD0..LD3, WRP on consecutive cycles
    request(1'b1, 32'h002B3F12, 32'hDDCCBBAA);
    chk_inst("w1_idle_inst", 13'h0000);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk_inst($sformatf("w1_inst%0d", i), w1[i]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk_inst($sformatf("w1_busy_inst%0d", i), 13'h0000);
      chk($sformatf("w1_busy_rsp%0d", i), {31'b0, bus.rsp_valid}, 32'd0);
    end
    step(1);
    chk("w1_done_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    step(1);
    chk("w1_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("w1_rsp_ready", {31'b0, bus.req_ready}, 32'd0);
    step(1);
    chk("w1_after_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk("w1_idle_ready", {31'b0, bus.req_ready}, 32'd1);

    // read same page: no LA, RDP first
    request(1'b0, 32'h002B3F12, 32'h0);
    step(1);
    chk_inst("r2_rdp", 13'h1A00);
    step(0);
    chk_inst("r2_busy", 13'h0000);
    step(1);
    chk("r2_done_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    step(1);
    chk("r2_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("r2_rsp_data", bus.rsp_data, 32'hDDCCBBAA);
    step(1);
    chk("r2_idle_ready", {31'b0, bus.req_ready}, 32'd1);

    // only LA3 differs; stall 3 cycles after LD1; no busy -> timeout
    ctl_page = 32'h11111111;
    request(1'b1, 32'h012B3F12, 32'h44332211);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_inst($sformatf("w3_inst%0d", i), w3[i]);
    end
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk_inst($sformatf("w3_stall%0d", i), 13'h0000);
    end
    step(1);
    chk_inst("w3_ld2", w3[3]);
    step(1);
    chk_inst("w3_ld3", 13'h1844);
    step(1);
    chk_inst("w3_wrp", 13'h1900);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("w3_wait_rsp%0d", i), {31'b0, bus.rsp_valid}, 32'd0);
      chk_inst($sformatf("w3_wait_inst%0d", i), 13'h0000);
    end
    step(1);
    chk("w3_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("w3_rsp_hold", bus.rsp_data, 32'hDDCCBBAA);
    step(1);
    chk("w3_after_rsp", {31'b0, bus.rsp_valid}, 32'd0);

    // reset during LOAD_D, then a read must reload all LA bytes
    request(1'b1, 32'h012B3F12, 32'h00000000);
    step(1);
    chk_inst("r4_ld0", 13'h1500);
    step(1);
    reset = 1'b1;
    #1;
    chk_inst("r4_rst_inst", 13'h0000);
    chk("r4_rst_ready", {31'b0, bus.req_ready}, 32'd0);
    step(1);
    chk("r4_rst_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk_inst("r4_rst_inst2", 13'h0000);
    step(1);
    reset = 1'b0;
    #1;
    chk("r4_post_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("r4_post_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk("r4_post_data", bus.rsp_data, 32'd0);
    ctl_page = 32'h5A5A0001;
    request(1'b0, 32'h012B3F12, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_inst($sformatf("r4_inst%0d", i), r4[i]);
    end
    step(0);
    chk_inst("r4_busy", 13'h0000);
    step(1);
    chk("r4_done_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    step(1);
    chk("r4_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("r4_rsp_data", bus.rsp_data, 32'h5A5A0001);
    step(1);
    chk("r4_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("r4_rsp_hold", bus.rsp_data, 32'h5A5A0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
